// File: rtl/axis_frame_pkg.sv
// Shared types and width helpers for the AXI-Stream frame buffer.
// Widths depend on module parameters, so the helpers are constant functions.
package axis_frame_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PREP  = 2'd1,
    DRAIN = 2'd2
  } fb_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 16;

  // One extra bit so a full count of DEPTH is representable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_frame_ram.sv
// Frame storage: register array, one synchronous write port, one asynchronous read port.
// No reset on the array; contents persist across frames.
module axis_frame_ram #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_frame_buffer.sv
// AXI-Stream frame buffer: captures one frame on s00, then replays it on m00.
// Capture and replay alternate; the FSM state is exposed on fsm_state.
module axis_frame_buffer
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                      s00_axis_tvalid,
  input  logic                      s00_axis_tlast,
  output logic                      s00_axis_tready,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,
  output logic [$clog2(DEPTH):0]    frame_len,
  output logic                      overflow,
  output fb_state_t                 fsm_state
);

  localparam int SW = strb_width(DATA_WIDTH);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int MW = DATA_WIDTH + SW;

  // Handshakes: a beat transfers on a rising edge where tvalid && tready.
  // m00 tvalid, once raised, stays high with stable payload until accepted;
  // s00 tready is registered and high only while filling.
  fb_state_t     state, state_next;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_cnt;
  logic          s_ready_q;
  logic          in_beat, wr_beat, close_last, close_full, out_hs;
  logic [MW-1:0] rd_word;

  assign s00_axis_tready = s_ready_q;
  assign fsm_state       = state;

  assign in_beat    = s00_axis_tvalid && s_ready_q;
  assign wr_beat    = in_beat && (s00_axis_tstrb != '0);
  assign wr_cnt     = wr_ptr + PW'(wr_beat);
  assign close_last = in_beat && s00_axis_tlast && (wr_cnt != '0);
  assign close_full = wr_beat && !s00_axis_tlast && (wr_cnt == PW'(DEPTH));
  assign out_hs     = m00_axis_tvalid && m00_axis_tready;

  axis_frame_ram #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (axis_aclk),
    .we    (wr_beat),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({s00_axis_tdata, s00_axis_tstrb}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) state <= FILL;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (close_last || close_full) state_next = PREP;
      PREP:    state_next = DRAIN;
      DRAIN:   if (out_hs && m00_axis_tlast) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      frame_len       <= '0;
      overflow        <= 1'b0;
      s_ready_q       <= 1'b1;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (wr_beat) wr_ptr <= wr_cnt;
          if (close_last || close_full) begin
            frame_len <= wr_cnt;
            s_ready_q <= 1'b0;
          end
          if (close_full) overflow <= 1'b1;
        end
        PREP: begin
          // rd_ptr is 0 here, so rd_word is the first stored word.
          {m00_axis_tdata, m00_axis_tstrb} <= rd_word;
          m00_axis_tvalid <= 1'b1;
          m00_axis_tlast  <= (frame_len == PW'(1));
          rd_ptr          <= PW'(1);
        end
        DRAIN: begin
          if (out_hs) begin
            if (m00_axis_tlast) begin
              m00_axis_tdata  <= '0;
              m00_axis_tstrb  <= '0;
              m00_axis_tvalid <= 1'b0;
              m00_axis_tlast  <= 1'b0;
              wr_ptr          <= '0;
              rd_ptr          <= '0;
              s_ready_q       <= 1'b1;
            end else begin
              {m00_axis_tdata, m00_axis_tstrb} <= rd_word;
              m00_axis_tlast <= (rd_ptr == frame_len - PW'(1));
              rd_ptr         <= rd_ptr + PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_buffer.sv
// Self-checking bench for axis_frame_buffer: scenario tasks against a queue-based frame model.
module tb_axis_frame_buffer;
  import axis_frame_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int SW    = DW / 8;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int BW    = DW + SW + 1;

  // clock / reset
  logic          axis_aclk = 1'b0;
  logic          axis_areset = 1'b1;
  logic [DW-1:0] s00_axis_tdata = '0;
  logic [SW-1:0] s00_axis_tstrb = '0;
  logic          s00_axis_tvalid = 1'b0;
  logic          s00_axis_tlast = 1'b0;
  logic          s00_axis_tready;
  logic [DW-1:0] m00_axis_tdata;
  logic [SW-1:0] m00_axis_tstrb;
  logic          m00_axis_tvalid;
  logic          m00_axis_tlast;
  logic          m00_axis_tready = 1'b0;
  logic [PW-1:0] frame_len;
  logic          overflow;
  fb_state_t     fsm_state;

  always #5 axis_aclk = ~axis_aclk;

  axis_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .axis_aclk       (axis_aclk),
    .axis_areset     (axis_areset),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tready (s00_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tready (m00_axis_tready),
    .frame_len       (frame_len),
    .overflow        (overflow),
    .fsm_state       (fsm_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard and reference model
  logic [BW-1:0]    in_q[$];        // {tlast, tstrb, tdata} beats still to send
  logic [BW-1:0]    exp_q[$];       // expected replayed beats
  logic [PW-1:0]    len_q[$];       // expected frame_len per closed frame
  logic [DW+SW-1:0] model_cur[$];   // words of the frame being collected
  logic             exp_ovf = 1'b0;

  task automatic model_clear();
    in_q.delete(); exp_q.delete(); len_q.delete(); model_cur.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    in_q.push_back({l, s, d});
    if (s != '0) model_cur.push_back({s, d});
    if ((l && model_cur.size() > 0) || model_cur.size() == DEPTH) begin
      if (!l) exp_ovf = 1'b1;
      len_q.push_back(PW'(model_cur.size()));
      foreach (model_cur[i]) exp_q.push_back({(i == model_cur.size() - 1), model_cur[i]});
      model_cur.delete();
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge axis_aclk);
    axis_areset = 1'b1;
    s00_axis_tvalid = 1'b0;
    m00_axis_tready = 1'b0;
    repeat (2) @(posedge axis_aclk);
    @(negedge axis_aclk);
    axis_areset = 1'b0;
    model_clear();
  endtask

  // mode 0: ready always, 1: ready toggles, 2: random ready and upstream gaps
  task automatic run_traffic(input int max_cycles, input int mode);
    int            cyc;
    logic          was_stalled;
    logic          in_hs;
    logic [BW-1:0] held, cur, exp;
    logic [PW-1:0] len_exp;
    cyc = 0;
    was_stalled = 1'b0;
    held = '0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
      @(negedge axis_aclk);
      if (in_q.size() > 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
        s00_axis_tvalid = 1'b1;
        {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata} = in_q[0];
      end else begin
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
      end
      if (mode == 0)      m00_axis_tready = 1'b1;
      else if (mode == 1) m00_axis_tready = ((cyc % 2) == 1);
      else                m00_axis_tready = ($urandom_range(0, 2) != 0);
      #1;
      cur = {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata};
      if (was_stalled) begin
        checks++;
        if (!m00_axis_tvalid || cur !== held) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b beat=%h, need valid=1 beat=%h", m00_axis_tvalid, cur, held);
        end
      end
      if (m00_axis_tvalid) begin
        checks++;
        if (s00_axis_tready !== 1'b0) begin
          errors++;
          $display("FAIL s_ready_in_drain: got %0b, need 0", s00_axis_tready);
        end
      end
      if (m00_axis_tvalid && m00_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got beat=%h, need no output", cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            errors++;
            $display("FAIL out_beat: got {last,strb,data}=%h, need %h", cur, exp);
          end
          if (exp[BW-1]) begin
            len_exp = len_q.pop_front();
            checks++;
            if (frame_len !== len_exp) begin
              errors++;
              $display("FAIL frame_len: got %0d, need %0d", frame_len, len_exp);
            end
          end
        end
      end
      was_stalled = m00_axis_tvalid && !m00_axis_tready;
      held = cur;
      in_hs = s00_axis_tvalid && s00_axis_tready;
      @(posedge axis_aclk);
      if (in_hs) void'(in_q.pop_front());
      cyc++;
    end
    checks++;
    if (in_q.size() > 0 || exp_q.size() > 0) begin
      errors++;
      $display("FAIL timeout: got %0d beats unsent and %0d words unseen, need 0 and 0", in_q.size(), exp_q.size());
      in_q.delete(); exp_q.delete(); len_q.delete();
    end
    @(negedge axis_aclk);
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
  endtask

  task automatic check_ovf(input string tag);
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow_%s: got %0b, need %0b", tag, overflow, exp_ovf);
    end
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (s00_axis_tready !== 1'b1 || m00_axis_tvalid !== 1'b0 || m00_axis_tlast !== 1'b0 ||
        m00_axis_tdata !== '0 || m00_axis_tstrb !== '0 || frame_len !== '0 ||
        overflow !== 1'b0 || fsm_state !== FILL) begin
      errors++;
      $display("FAIL reset_state: got ready=%0b valid=%0b last=%0b data=%h strb=%h len=%0d ovf=%0b state=%0d, need 1 0 0 0 0 0 0 0",
               s00_axis_tready, m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, m00_axis_tstrb,
               frame_len, overflow, fsm_state);
    end
  endtask

  task automatic test_basic();
    push_beat(32'hA1, 4'hF, 1'b0);
    push_beat(32'hB2, 4'hF, 1'b0);
    push_beat(32'hC3, 4'hF, 1'b1);
    m00_axis_tready = 1'b0;
    while (in_q.size() > 0) begin
      @(negedge axis_aclk);
      s00_axis_tvalid = 1'b1;
      {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata} = in_q.pop_front();
      @(posedge axis_aclk);
    end
    #1;
    checks++;
    if (m00_axis_tvalid !== 1'b0 || s00_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_close: got valid=%0b ready=%0b, need 0 0", m00_axis_tvalid, s00_axis_tready);
    end
    @(negedge axis_aclk);
    s00_axis_tvalid = 1'b0;
    @(posedge axis_aclk);
    #1;
    checks++;
    if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== 32'hA1 || m00_axis_tlast !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: got valid=%0b data=%h last=%0b, need 1 a1 0", m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast);
    end
    run_traffic(50, 0);
    checks++;
    if (s00_axis_tready !== 1'b1 || m00_axis_tvalid !== 1'b0 || frame_len !== PW'(3)) begin
      errors++;
      $display("FAIL basic_after_drain: got ready=%0b valid=%0b len=%0d, need 1 0 3", s00_axis_tready, m00_axis_tvalid, frame_len);
    end
    check_ovf("basic");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) push_beat($urandom(), 4'hF, i == 3);
    for (int i = 0; i < 3; i++) push_beat($urandom(), SW'($urandom_range(1, 15)), i == 2);
    run_traffic(200, 1);
    check_ovf("backpressure");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 18; i++) push_beat(DW'(i), 4'hF, 1'b0);
    push_beat(32'hDEAD, 4'h0, 1'b1);
    run_traffic(200, 0);
    check_ovf("overflow");
  endtask

  task automatic test_null_beats();
    push_beat(32'h11, 4'h1, 1'b0);
    push_beat($urandom(), 4'h0, 1'b0);
    push_beat(32'h22, 4'h3, 1'b1);
    run_traffic(100, 0);
    push_beat($urandom(), 4'h0, 1'b1);
    run_traffic(20, 0);
    repeat (3) @(posedge axis_aclk);
    #1;
    checks++;
    if (fsm_state !== FILL || m00_axis_tvalid !== 1'b0 || frame_len !== PW'(2) || s00_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL lone_null_tlast: got state=%0d valid=%0b len=%0d ready=%0b, need 0 0 2 1",
               fsm_state, m00_axis_tvalid, frame_len, s00_axis_tready);
    end
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        push_beat($urandom(), ($urandom_range(0, 5) == 0) ? SW'(0) : SW'($urandom_range(1, 15)), i == len - 1);
    end
    run_traffic(3000, 2);
    check_ovf("random");
  endtask

  task automatic test_reset_mid_drain();
    logic [DW-1:0] words [5];
    int n;
    do_reset();
    foreach (words[i]) words[i] = $urandom();
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_aclk);
      s00_axis_tvalid = 1'b1;
      s00_axis_tstrb  = 4'hF;
      s00_axis_tdata  = words[i];
      s00_axis_tlast  = (i == 4);
      @(posedge axis_aclk);
    end
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge axis_aclk);
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
      m00_axis_tready = 1'b1;
      #1;
      if (m00_axis_tvalid) begin
        checks++;
        if (m00_axis_tdata !== words[n] || m00_axis_tlast !== 1'b0) begin
          errors++;
          $display("FAIL pre_reset_word%0d: got data=%h last=%0b, need %h 0", n, m00_axis_tdata, m00_axis_tlast, words[n]);
        end
        n++;
      end
      @(posedge axis_aclk);
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL pre_reset_timeout: got %0d words, need 2", n);
    end
    @(negedge axis_aclk);
    axis_areset = 1'b1;
    @(posedge axis_aclk);
    #1;
    checks++;
    if (m00_axis_tvalid !== 1'b0 || m00_axis_tlast !== 1'b0 || m00_axis_tdata !== '0 ||
        m00_axis_tstrb !== '0 || overflow !== 1'b0 || frame_len !== '0 || s00_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain_reset: got valid=%0b last=%0b data=%h strb=%h ovf=%0b len=%0d ready=%0b, need 0 0 0 0 0 0 1",
               m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, m00_axis_tstrb, overflow, frame_len, s00_axis_tready);
    end
    @(negedge axis_aclk);
    axis_areset = 1'b0;
    model_clear();
    push_beat($urandom(), 4'h5, 1'b1);
    run_traffic(50, 0);
    check_ovf("after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, need finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_null_beats();
    test_overflow();
    test_random();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_buffer.md
# axis_frame_buffer

Single-clock AXI-Stream frame buffer at the memory side of the write path: it is the sink for the memory controller's master stream. It accepts a frame of words on its slave port, stores them in an internal register array, then replays the complete frame on its master port for read-back. Capture and replay alternate and never overlap, so the block also serves as a loop-back memory for system-level checks of the controller.

## Interface
- DATA_WIDTH, 32, stream data width in bits; must be a multiple of 8
- DEPTH, 16, maximum words per frame; must be a power of two, ≥ 2
- axis_aclk  input  1  sole clock; all logic on the rising edge
- axis_areset  input  1  synchronous, active-high reset
- s00_axis_tdata  input  DATA_WIDTH  incoming word
- s00_axis_tstrb  input  DATA_WIDTH/8  incoming byte qualifiers
- s00_axis_tvalid  input  1  incoming word valid
- s00_axis_tlast  input  1  last word of frame
- s00_axis_tready  output  1  buffer can accept a word
- m00_axis_tdata  output  DATA_WIDTH  replayed word
- m00_axis_tstrb  output  DATA_WIDTH/8  replayed qualifiers, exactly as stored
- m00_axis_tvalid  output  1  replayed word valid
- m00_axis_tlast  output  1  last word of replayed frame
- m00_axis_tready  input  1  downstream accepts a word
- frame_len  output  $clog2(DEPTH)+1  word count of the most recently closed frame
- overflow  output  1  sticky: a frame was truncated at DEPTH words

## Operation
- FSM states: FILL, PREP, DRAIN.
- FILL:
  - s00_axis_tready = 1.
  - An input beat is a handshake where tvalid && tready.
  - A beat with tstrb ≠ 0 writes {tdata, tstrb} to mem[wr_ptr] and increments wr_ptr.
  - A beat with tstrb == 0 is a null beat: it is accepted and discarded.
- Frame close happens on the first of these events:
  - A beat with tlast = 1 and at least one word stored, including the word written on that beat. The FSM moves to PREP and frame_len is set to the stored count.
  - A non-null beat that fills the DEPTH-th location without tlast. frame_len = DEPTH, overflow is set, and the FSM moves to PREP. Any remainder of the upstream frame is accepted as new data once the FSM returns to FILL.
- A null beat with tlast and zero words stored closes nothing: the FSM stays in FILL and frame_len is unchanged.
- PREP (exactly one cycle):
  - s00_axis_tready = 0.
  - mem[0] is loaded into the output registers, rd_ptr = 1.
  - m00_axis_tvalid is set to 1.
  - m00_axis_tlast = (frame_len == 1).
  - The FSM moves to DRAIN.
- DRAIN:
  - s00_axis_tready = 0; upstream traffic is stalled, never dropped.
  - Output registers are held stable while tvalid && !tready.
  - On an output handshake that is not the last word: load mem[rd_ptr], increment rd_ptr, and set tlast when rd_ptr == frame_len-1.
  - On the handshake of the tlast word: tvalid = 0, tdata/tstrb/tlast = 0, wr_ptr = rd_ptr = 0, and the FSM returns to FILL.
- Memory contents persist across frames. Reads are only ever issued below frame_len.
- overflow clears only on reset.

## Timing
- Reset (axis_areset = 1 at an edge) forces:
  - FSM = FILL, pointers = 0, frame_len = 0, overflow = 0
  - s00_axis_tready = 1 from the first cycle after the reset edge
  - all m00 outputs = 0
- Reset mid-frame or mid-drain discards the frame immediately; no tlast is emitted.
- s00_axis_tready is a registered output. It drops in the cycle after the closing beat's edge and rises in the cycle after the final output handshake.
- Latency: closing beat at edge N → m00_axis_tvalid = 1 after edge N+1.
- Throughput: one word per cycle in both directions. Total time is frame_len input cycles + 1 PREP cycle + frame_len output cycles, with no backpressure.
- m00_axis_tvalid never deasserts before its handshake (AXI-Stream rule). m00 outputs do not combinationally depend on m00_axis_tready.
- wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, so a count of DEPTH is representable; there is no wrap-around within a frame.

## Structure
- Package axis_frame_pkg holds:
  - typedef enum logic [1:0] {FILL, PREP, DRAIN} fb_state_t
  - localparam helpers for pointer width ($clog2(DEPTH)+1) and strobe width (DATA_WIDTH/8)
- Sub-module axis_frame_ram: DEPTH × (DATA_WIDTH + DATA_WIDTH/8) register array with one synchronous write port and one asynchronous read port.
- The top level contains only the FSM, pointers, output registers and status.

## Test plan
- Basic frame: DEPTH = 16; send 3 words 0xA1, 0xB2, 0xC3, tstrb = 0xF, tlast on 0xC3; m00_axis_tready = 1. Expect:
  - frame_len = 3 and overflow = 0
  - outputs 0xA1, 0xB2, 0xC3 with tlast only on 0xC3
  - first tvalid 2 cycles after the closing beat's edge; tready back to 1 after the drain
- Backpressure: 4-word frame; toggle m00_axis_tready every other cycle. Expect:
  - data held stable while stalled
  - no duplicate or missing words
  - s00_axis_tready = 0 throughout the drain, even with s00_axis_tvalid = 1 upstream
- Overflow: send 18 words 0..17 with no tlast. Expect:
  - closure after word 15, overflow = 1, frame_len = 16
  - drain of 0..15 with tlast on 15
  - words 16 and 17, held upstream, captured as the next frame
- Null beats: send 0x11 (tstrb = 0x1), a null beat, then 0x22 (tstrb = 0x3, tlast). Expect output 0x11/0x1, 0x22/0x3 and frame_len = 2. Separately, a lone null tlast beat leaves the block in FILL with no output.
- Reset mid-drain: assert axis_areset after the 2nd of 5 output words. Expect:
  - all m00 outputs = 0 next cycle, overflow = 0, frame_len = 0
  - s00_axis_tready = 1, and a fresh 1-word frame is then replayed correctly
